// File: rtl/arm_shift_pkg.sv
// Shared types and operand-2 field positions for the shifter front end.
package arm_shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RD_RS = 2'b01,
    RD_RM = 2'b10,
    OUT   = 2'b11
  } sog_state_t;

  // Instruction bit positions
  localparam int unsigned I_BIT      = 25;
  localparam int unsigned RS_MSB     = 11;
  localparam int unsigned RS_LSB     = 8;
  localparam int unsigned ROT_MSB    = 11;
  localparam int unsigned ROT_LSB    = 8;
  localparam int unsigned AMT_MSB    = 11;
  localparam int unsigned AMT_LSB    = 7;
  localparam int unsigned IMM8_MSB   = 7;
  localparam int unsigned OP_MSB     = 6;
  localparam int unsigned OP_LSB     = 5;
  localparam int unsigned REG_SH_BIT = 4;
  localparam int unsigned RM_MSB     = 3;
  localparam int unsigned RM_LSB     = 0;

endpackage

// File: rtl/shift_operand_gen_op2_decode.sv
// Combinational decode of the operand-2 field: register addresses,
// shift type and the immediate shift amount with its #0 encodings.
module op2_decode
  import arm_shift_pkg::*;
(
  input  logic        i_bit,
  input  logic [11:0] op2,
  output logic [3:0]  rm_addr,
  output logic [3:0]  rs_addr,
  output logic        reg_shift,
  output logic [31:0] imm_amt,
  output shift_op_t   shift_op,
  output logic        rrx
);

  logic [4:0] amt5;
  shift_op_t  field_op;

  assign amt5     = op2[AMT_MSB:AMT_LSB];
  assign field_op = shift_op_t'(op2[OP_MSB:OP_LSB]);
  assign rm_addr  = op2[RM_MSB:RM_LSB];
  assign rs_addr  = op2[RS_MSB:RS_LSB];

  // Select shift type and amount; a zero immediate amount re-encodes LSR/ASR as 32 and ROR as RRX
  always_comb begin
    reg_shift = 1'b0;
    imm_amt   = 32'd0;
    shift_op  = LSL;
    rrx       = 1'b0;
    if (i_bit) begin
      shift_op = ROR;
      imm_amt  = {27'd0, op2[ROT_MSB:ROT_LSB], 1'b0};
    end else if (op2[REG_SH_BIT]) begin
      reg_shift = 1'b1;
      shift_op  = field_op;
    end else begin
      shift_op = field_op;
      imm_amt  = {27'd0, amt5};
      if (amt5 == 5'd0) begin
        case (field_op)
          LSR, ASR: imm_amt = 32'd32;
          ROR: begin
            imm_amt = 32'd1;
            rrx     = 1'b1;
          end
          default: imm_amt = 32'd0;
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_operand_gen.sv
// Shifter operand front end: accepts a data-processing instruction,
// reads Rs/Rm from the register file and presents shift operands.
module shift_operand_gen
  import arm_shift_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        carry_in,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] shift_in,
  output logic [1:0]  shift_op,
  output logic [31:0] shift_amt,
  output logic        rrx,
  output logic        rrx_carry
);

  sog_state_t  state_reg;
  logic        i_reg;
  logic [11:0] op2_reg;

  logic        dec_i;
  logic [11:0] dec_op2;
  logic [3:0]  dec_rm;
  logic [3:0]  dec_rs;
  logic        dec_reg_shift;
  logic [31:0] dec_amt;
  shift_op_t   dec_op;
  logic        dec_rrx;
  logic        instr_unused;

  // Only I and the operand-2 field matter here
  assign instr_unused = ^{instr[31:26], instr[24:12]};

  // In IDLE decode the incoming instruction so accept-time captures are ready; afterwards decode the latched copy
  assign dec_i   = (state_reg == IDLE) ? instr[I_BIT] : i_reg;
  assign dec_op2 = (state_reg == IDLE) ? instr[11:0]  : op2_reg;

  op2_decode u_op2_decode (
    .i_bit     (dec_i),
    .op2       (dec_op2),
    .rm_addr   (dec_rm),
    .rs_addr   (dec_rs),
    .reg_shift (dec_reg_shift),
    .imm_amt   (dec_amt),
    .shift_op  (dec_op),
    .rrx       (dec_rrx)
  );

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == OUT);

  // Register-file address is driven only during the two read states
  always_comb begin
    rf_addr = 4'd0;
    case (state_reg)
      RD_RS:   rf_addr = dec_rs;
      RD_RM:   rf_addr = dec_rm;
      default: rf_addr = 4'd0;
    endcase
  end

  // Sequencer, instruction latch and operand capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      i_reg     <= 1'b0;
      op2_reg   <= 12'd0;
      shift_in  <= 32'd0;
      shift_op  <= 2'b00;
      shift_amt <= 32'd0;
      rrx       <= 1'b0;
      rrx_carry <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            i_reg     <= instr[I_BIT];
            op2_reg   <= instr[11:0];
            rrx_carry <= carry_in;
            if (dec_i) begin
              shift_in  <= {24'd0, instr[IMM8_MSB:0]};
              shift_op  <= dec_op;
              shift_amt <= dec_amt;
              rrx       <= 1'b0;
              state_reg <= OUT;
            end else if (dec_reg_shift) begin
              rrx       <= 1'b0;
              state_reg <= RD_RS;
            end else begin
              shift_amt <= dec_amt;
              rrx       <= dec_rrx;
              state_reg <= RD_RM;
            end
          end
        end
        RD_RS: begin
          shift_amt <= {24'd0, rf_data[7:0]};
          state_reg <= RD_RM;
        end
        RD_RM: begin
          shift_in  <= rf_data;
          shift_op  <= dec_op;
          state_reg <= OUT;
        end
        OUT: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_operand_gen.sv
// Self-checking bench for shift_operand_gen: directed vector table,
// reset sequences and randomized instructions against a reference model.
module tb_shift_operand_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        carry_in;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shift_in;
  logic [1:0]  shift_op;
  logic [31:0] shift_amt;
  logic        rrx;
  logic        rrx_carry;

  logic [31:0] regs [16];

  int checks   = 0;
  int failures = 0;
  int txn_no   = 0;

  always #5 clk = ~clk;

  assign rf_data = regs[rf_addr];

  shift_operand_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .carry_in  (carry_in),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .shift_in  (shift_in),
    .shift_op  (shift_op),
    .shift_amt (shift_amt),
    .rrx       (rrx),
    .rrx_carry (rrx_carry)
  );

  typedef struct {
    logic [31:0] ins;
    logic        cin;
    int          hold;
    logic [31:0] exp_in;
    logic [1:0]  exp_op;
    logic [31:0] exp_amt;
    logic        exp_rrx;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: operand set an ARM data-processing operand 2 denotes
  task automatic model(input logic [31:0] ins, output logic [31:0] e_in, output logic [1:0] e_op,
                       output logic [31:0] e_amt, output logic e_rrx, output int e_lat);
    int n;
    e_rrx = 1'b0;
    if (ins[25]) begin
      e_in  = 32'(ins[7:0]);
      e_op  = 2'b11;
      e_amt = 32'(2 * int'(ins[11:8]));
      e_lat = 1;
    end else if (ins[4]) begin
      e_in  = regs[ins[3:0]];
      e_op  = ins[6:5];
      e_amt = regs[ins[11:8]] % 256;
      e_lat = 3;
    end else begin
      n     = int'(ins[11:7]);
      e_in  = regs[ins[3:0]];
      e_op  = ins[6:5];
      e_amt = 32'(n);
      e_lat = 2;
      if (n == 0 && (e_op == 2'b01 || e_op == 2'b10)) e_amt = 32;
      if (n == 0 && e_op == 2'b11) begin
        e_amt = 1;
        e_rrx = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_shift_in"},  shift_in,       32'd0);
    chk({tag, "_shift_op"},  32'(shift_op),  32'd0);
    chk({tag, "_shift_amt"}, shift_amt,      32'd0);
    chk({tag, "_rrx"},       32'(rrx),       32'd0);
    chk({tag, "_rrx_carry"}, 32'(rrx_carry), 32'd0);
    chk({tag, "_rf_addr"},   32'(rf_addr),   32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_txn(input logic [31:0] ins, input logic cin, input int hold,
                         input logic [31:0] e_in, input logic [1:0] e_op,
                         input logic [31:0] e_amt, input logic e_rrx, input int e_lat);
    logic [3:0] ra [2];
    int nreads;
    int rd_idx;
    int lat;
    bit got;
    if (ins[25]) nreads = 0;
    else if (ins[4]) begin
      nreads = 2; ra[0] = ins[11:8]; ra[1] = ins[3:0];
    end else begin
      nreads = 1; ra[0] = ins[3:0];
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    instr    = ins;
    carry_in = cin;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0; rd_idx = 0; got = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      instr    = $urandom;
      carry_in = ~cin;
      if (out_valid) begin
        lat = c; got = 1;
        break;
      end
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (rd_idx < nreads) chk("rf_addr_seq", 32'(rf_addr), 32'(ra[rd_idx]));
      else chk("rf_addr_extra_read", 32'(rf_addr), 32'd0);
      rd_idx++;
    end
    if (!got) begin
      failures++;
      checks++;
      $display("FAIL out_valid_timeout actual=none required=latency %0d", e_lat);
      do_reset();
      return;
    end
    chk("latency",   32'(lat),       32'(e_lat));
    chk("shift_in",  shift_in,       e_in);
    chk("shift_op",  32'(shift_op),  32'(e_op));
    chk("shift_amt", shift_amt,      e_amt);
    chk("rrx",       32'(rrx),       32'(e_rrx));
    chk("rrx_carry", 32'(rrx_carry), 32'(cin));
    chk("rf_addr_out", 32'(rf_addr), 32'd0);
    chk("in_ready_out", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_shift_in",  shift_in,       e_in);
      chk("hold_shift_amt", shift_amt,      e_amt);
      chk("hold_shift_op",  32'(shift_op),  32'(e_op));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready",  32'(in_ready),  32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_shift_in",  shift_in,       e_in);
    $display("txn %0d instr=%h carry=%0d hold=%0d lat=%0d shift_in=%h op=%0d amt=%0d rrx=%0d",
             txn_no, ins, cin, hold, lat, shift_in, shift_op, shift_amt, rrx);
    txn_no++;
  endtask

  vec_t vecs [9];

  initial begin
    logic [31:0] m_in;
    logic [1:0]  m_op;
    logic [31:0] m_amt;
    logic        m_rrx;
    int          m_lat;
    logic [31:0] r_ins;

    for (int i = 0; i < 16; i++) regs[i] = 32'h0;
    regs[1] = 32'hAAAAAAAA;
    regs[2] = 32'h80000000;
    regs[3] = 32'h00000104;
    regs[4] = 32'h12345600;

    //           instr          cin  hold exp_in         op     amt    rrx  lat
    vecs[0] = '{32'h020001FF, 1'b0, 0, 32'h000000FF, 2'b11, 32'd2,  1'b0, 1};
    vecs[1] = '{32'h00000022, 1'b0, 0, 32'h80000000, 2'b01, 32'd32, 1'b0, 2};
    vecs[2] = '{32'h00000061, 1'b1, 0, 32'hAAAAAAAA, 2'b11, 32'd1,  1'b1, 2};
    vecs[3] = '{32'h00000351, 1'b0, 0, 32'hAAAAAAAA, 2'b10, 32'd4,  1'b0, 3};
    vecs[4] = '{32'h00000281, 1'b1, 5, 32'hAAAAAAAA, 2'b00, 32'd5,  1'b0, 2};
    vecs[5] = '{32'h00000042, 1'b0, 0, 32'h80000000, 2'b10, 32'd32, 1'b0, 2};
    vecs[6] = '{32'h00000002, 1'b0, 0, 32'h80000000, 2'b00, 32'd0,  1'b0, 2};
    vecs[7] = '{32'h02000F80, 1'b1, 2, 32'h00000080, 2'b11, 32'd30, 1'b0, 1};
    vecs[8] = '{32'h00000412, 1'b0, 0, 32'h80000000, 2'b00, 32'd0,  1'b0, 3};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i])
      run_txn(vecs[i].ins, vecs[i].cin, vecs[i].hold, vecs[i].exp_in, vecs[i].exp_op,
              vecs[i].exp_amt, vecs[i].exp_rrx, vecs[i].exp_lat);

    // Reset while reading Rs aborts the instruction
    instr = 32'h00000351; carry_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_rf_addr_rs", 32'(rf_addr), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("abort");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_out_valid", 32'(out_valid), 32'd0);
    end

    // Randomized instructions and register contents
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      r_ins = $urandom;
      model(r_ins, m_in, m_op, m_amt, m_rrx, m_lat);
      run_txn(r_ins, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              m_in, m_op, m_amt, m_rrx, m_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_operand_gen.md
# shift_operand_gen

Sequential front end for the data-processing barrel shifter. It accepts a data-processing instruction, decodes the operand-2 field, and reads Rm (and Rs for register-specified shifts) from the register file over a request port. It then presents `shift_in`/`shift_op`/`shift_amt` to the shifter with a valid/ready handshake. It is the initiator side of the shifter interface, sitting between decode and the execute-stage shifter.

## Interface
Parameters:
- none; all widths are fixed by the ARM32 datapath.

Ports:
- `clk` in 1 — the single clock.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — an instruction is offered.
- `in_ready` out 1 — the block can accept an instruction.
- `instr` in 32 — the instruction; only bit 25 (I) and bits [11:0] are used.
- `carry_in` in 1 — current C flag, sampled at accept.
- `rf_addr` out 4 — register-file read address.
- `rf_data` in 32 — combinational read data for `rf_addr`, valid in the same cycle.
- `out_valid` out 1 — the shifter operands are valid.
- `out_ready` in 1 — the shifter/execute stage consumes the operands.
- `shift_in` out 32 — value to shift.
- `shift_op` out 2 — 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `shift_amt` out 32 — shift amount, zero-extended.
- `rrx` out 1 — the operation is RRX; downstream replaces result bit 31 with `rrx_carry`.
- `rrx_carry` out 1 — `carry_in` latched at accept.

## Operation
- States: IDLE, RD_RS, RD_RM, OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch `instr` and `carry_in`.
  - Next state: OUT if I=1; RD_RS if I=0 and bit4=1; RD_RM otherwise.
- **Immediate form (I=1)**
  - `shift_in` = zero-extended `instr[7:0]`.
  - `shift_op` = 11.
  - `shift_amt` = `2*instr[11:8]`, range 0..30.
  - No register read.
- **RD_RS**
  - `rf_addr` = `instr[11:8]`.
  - Capture `shift_amt` = zero-extended `rf_data[7:0]`; upper bits of Rs are ignored.
  - Next state: RD_RM.
- **RD_RM**
  - `rf_addr` = `instr[3:0]`.
  - Capture `shift_in` = `rf_data`; `shift_op` = `instr[6:5]`.
  - Next state: OUT.
- **Immediate shift amount (I=0, bit4=0)**: `shift_amt` = `instr[11:7]`, with these encodings of 0:
  - LSL #0 → amt 0.
  - LSR #0 → amt 32.
  - ASR #0 → amt 32.
  - ROR #0 → RRX: `rrx`=1, `shift_op`=11, `shift_amt`=1.
- **Register shift amount**: Rs amounts 0..255 are passed unmodified; an amount of 0 means no shift. `rrx` is never set for register shifts.
- **OUT**
  - `out_valid`=1; all outputs are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- Outside OUT, `out_valid`=0 and the data outputs hold their last values.
- Outside RD_RS/RD_RM, `rf_addr` = 0.
- R15 handling (PC offset) belongs to the register file; this block reads whatever `rf_data` returns.
- Reset values:
  - state = IDLE, `in_ready`=1, `out_valid`=0.
  - `shift_in`=0, `shift_op`=00, `shift_amt`=0.
  - `rrx`=0, `rrx_carry`=0, `rf_addr`=0.

## Timing
- Accept happens at the rising edge where `in_valid && in_ready`.
- Latency from accept to `out_valid`:
  - immediate form: 1 cycle;
  - register with immediate shift: 2 cycles;
  - register with register shift: 3 cycles.
- `in_ready` is deasserted from accept until the cycle after the output handshake; there is no overlap, so maximum throughput is one operand set per 2 cycles.
- `rf_data` is sampled at the end of the cycle in which `rf_addr` is driven.
- In RD_RS/RD_RM, `out_ready` is ignored.
- `rst` wins over every other event in the same cycle. Reset mid-operation discards the latched instruction; the next cycle is IDLE with reset outputs, and no `out_valid` is produced for the aborted instruction.

## Structure
- Shared package `arm_shift_pkg`:
  - `shift_op_t` enum (LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11);
  - `sog_state_t` enum;
  - constants for the operand-2 field positions.
- One combinational sub-module, `op2_decode`, turns latched `instr[11:0]` plus I into: rm/rs addresses, a reg-shift flag, the immediate amount, `shift_op`, and the rrx flag, including the #0 special cases.
- The FSM, capture registers and handshake live in `shift_operand_gen`.

## Test plan
- **Immediate form.** I=1, `instr[11:0]`=12'h1FF.
  - Response 1 cycle after accept: `out_valid`, `shift_in`=32'h000000FF, `shift_op`=11, `shift_amt`=2, `rrx`=0.
- **LSR #0.** I=0, Rm=r2 holding 32'h80000000, `instr[11:4]`=8'h02.
  - Response: `shift_op`=01, `shift_amt`=32.
  - `rf_addr`=2 in the single read cycle; `out_valid` 2 cycles after accept.
- **ROR #0 (RRX).** `instr[6:4]`=3'b110 with `carry_in`=1.
  - Response: `rrx`=1, `rrx_carry`=1, `shift_op`=11, `shift_amt`=1.
- **Register shift.** Rs=r3 holding 32'h00000104, Rm=r1 holding 32'hAAAAAAAA, ASR (`instr[6:4]`=3'b101).
  - `rf_addr` sequence 3 then 1.
  - Response: `shift_amt`=4, `shift_in`=32'hAAAAAAAA, `shift_op`=10, `out_valid` 3 cycles after accept.
- **Backpressure.** `out_ready` held 0 for 5 cycles in OUT.
  - Outputs stay stable and `in_ready`=0 throughout.
  - After the handshake, `in_ready`=1 the next cycle and a new instruction is accepted.
- **Reset mid-operation.** Assert `rst` while in RD_RS.
  - Next cycle: IDLE, `in_ready`=1, all outputs at their reset values.
  - No stray `out_valid` afterwards.
